apo_input_arbiter: RTL

- Input scheduler placed in front of the circulant router core (C(49; 4, 5)).
- Captures packets from the five router inputs (IP port plus four neighbour ports) into per-port 2-deep FIFOs.
- Grants one packet per cycle to the core, round-robin and gated by the core's ready signal.
- Replaces fixed-priority input selection, which loses packets that arrive in the same cycle.

---
 rtl/apo_input_arbiter_if.sv | 28 ++
 rtl/apo_input_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/apo_input_arbiter_if.sv
// Bundle of router-input packets, core handshake and status lines around the input arbiter.
// The master side drives packets into the arbiter; the slave side is the arbiter itself.
interface apo_input_arbiter_if #(
    parameter int PKT_W  = 13,
    parameter int DROP_W = 8
);
    logic [PKT_W-1:0]  in_free;
    logic [PKT_W-1:0]  in_r1R;
    logic [PKT_W-1:0]  in_r2R;
    logic [PKT_W-1:0]  in_r1L;
    logic [PKT_W-1:0]  in_r2L;
    logic              core_ready;
    logic [PKT_W-1:0]  out_pkt;
    logic [2:0]        out_src;
    logic              out_from_ip;
    logic [4:0]        full;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output in_free, in_r1R, in_r2R, in_r1L, in_r2L, core_ready,
        input  out_pkt, out_src, out_from_ip, full, drop_cnt
    );

    modport slave (
        input  in_free, in_r1R, in_r2R, in_r1L, in_r2L, core_ready,
        output out_pkt, out_src, out_from_ip, full, drop_cnt
    );
endinterface

// File: rtl/apo_input_arbiter.sv
// Round-robin input scheduler for the circulant router core: five 2-deep input FIFOs feed
// one registered output slot, granted one packet per cycle under the core's ready signal.
module apo_input_arbiter #(
    parameter int PKT_W  = 13,
    parameter int DEPTH  = 2,
    parameter int DROP_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    apo_input_arbiter_if.slave  bus
);
    localparam int NP = 5;

    typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

    state_t            state_q, state_d;
    logic [PKT_W-1:0]  mem_q [NP][DEPTH];
    logic [NP-1:0]     rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [1:0]        cnt_q [NP];
    logic [1:0]        cnt_d [NP];
    logic [2:0]        rrPtr_q, rrPtr_d;
    logic [PKT_W-1:0]  outPkt_q, outPkt_d;
    logic [2:0]        outSrc_q, outSrc_d;
    logic              fromIp_q, fromIp_d;
    logic [NP-1:0]     full_q, full_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [PKT_W-1:0]  inPkt [NP];
    logic [NP-1:0]     push, pop;
    logic              load, found, anyNext;
    logic [2:0]        winner, dropNum;
    logic [3:0]        idx;
    logic [DROP_W:0]   dropSum;

    assign inPkt[0] = bus.in_free;
    assign inPkt[1] = bus.in_r1R;
    assign inPkt[2] = bus.in_r2R;
    assign inPkt[3] = bus.in_r1L;
    assign inPkt[4] = bus.in_r2L;

    // Arbitration works only on registered FIFO state, so no input reaches an output combinationally.
    always_comb begin
        state_d  = state_q;
        rrPtr_d  = rrPtr_q;
        outPkt_d = outPkt_q;
        outSrc_d = outSrc_q;
        fromIp_d = fromIp_q;
        push     = '0;
        pop      = '0;
        found    = 1'b0;
        winner   = 3'd0;
        idx      = 4'd0;
        dropNum  = 3'd0;
        anyNext  = 1'b0;
        load     = !outPkt_q[PKT_W-1] || bus.core_ready;

        if (state_q != IDLE && load) begin
            for (int k = 0; k < NP; k++) begin
                idx = {1'b0, rrPtr_q} + 4'(k);
                if (idx >= 4'(NP)) idx = idx - 4'(NP);
                if (!found && cnt_q[idx[2:0]] != 2'd0) begin
                    found  = 1'b1;
                    winner = idx[2:0];
                end
            end
        end

        if (load) begin
            if (found) begin
                outPkt_d    = mem_q[winner][rdPtr_q[winner]];
                outSrc_d    = winner;
                fromIp_d    = (winner == 3'd0);
                pop[winner] = 1'b1;
                rrPtr_d     = (winner == 3'(NP-1)) ? 3'd0 : winner + 3'd1;
            end else begin
                outPkt_d = '0;
                outSrc_d = 3'd0;
                fromIp_d = 1'b0;
            end
        end

        // A full port still accepts when its head leaves in the same cycle.
        for (int i = 0; i < NP; i++) begin
            if (inPkt[i][PKT_W-1]) begin
                if (cnt_q[i] != 2'(DEPTH) || pop[i]) push[i] = 1'b1;
                else dropNum = dropNum + 3'd1;
            end
            cnt_d[i]   = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            full_d[i]  = (cnt_d[i] == 2'(DEPTH));
            rdPtr_d[i] = rdPtr_q[i] ^ pop[i];
            wrPtr_d[i] = wrPtr_q[i] ^ push[i];
            if (cnt_d[i] != 2'd0) anyNext = 1'b1;
        end

        dropSum = {1'b0, drop_q} + (DROP_W+1)'(dropNum);
        drop_d  = dropSum[DROP_W] ? {DROP_W{1'b1}} : dropSum[DROP_W-1:0];

        if (!anyNext && !outPkt_d[PKT_W-1]) state_d = IDLE;
        else if (outPkt_q[PKT_W-1] && !bus.core_ready) state_d = STALL;
        else state_d = GRANT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rdPtr_q  <= '0;
            wrPtr_q  <= '0;
            rrPtr_q  <= 3'd0;
            outPkt_q <= '0;
            outSrc_q <= 3'd0;
            fromIp_q <= 1'b0;
            full_q   <= '0;
            drop_q   <= '0;
            for (int i = 0; i < NP; i++) cnt_q[i] <= 2'd0;
        end else begin
            state_q  <= state_d;
            rdPtr_q  <= rdPtr_d;
            wrPtr_q  <= wrPtr_d;
            rrPtr_q  <= rrPtr_d;
            outPkt_q <= outPkt_d;
            outSrc_q <= outSrc_d;
            fromIp_q <= fromIp_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
            for (int i = 0; i < NP; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) mem_q[i][wrPtr_q[i]] <= inPkt[i];
            end
        end
    end

    assign bus.out_pkt     = outPkt_q;
    assign bus.out_src     = outSrc_q;
    assign bus.out_from_ip = fromIp_q;
    assign bus.full        = full_q;
    assign bus.drop_cnt    = drop_q;
endmodule
